axi_ram_slave: RTL

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_ram_pkg.sv | 10 +
 rtl/axi_ram_slave_if.sv | 46 ++++
 rtl/axi_ram_addr_gen.sv | 24 ++
 rtl/axi_ram_slave.sv | 91 +++++++++
 4 files changed

// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: burst/response encodings and channel FSM states shared by the AXI RAM slave
package axi_ram_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [1:0] BURST_WRAP = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;
endpackage

// File: rtl/axi_ram_slave_if.sv
// axi_ram_slave_if: AXI4 write/read channel bundle between a master and the RAM slave
interface axi_ram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [7:0] s_axi_awlen;
  logic [2:0] s_axi_awsize;
  logic [1:0] s_axi_awburst;
  logic s_axi_awvalid;
  logic s_axi_awready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic [STRB_WIDTH-1:0] s_axi_wstrb;
  logic s_axi_wlast;
  logic s_axi_wvalid;
  logic s_axi_wready;
  logic [1:0] s_axi_bresp;
  logic s_axi_bvalid;
  logic s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0] s_axi_arlen;
  logic [2:0] s_axi_arsize;
  logic [1:0] s_axi_arburst;
  logic s_axi_arvalid;
  logic s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0] s_axi_rresp;
  logic s_axi_rlast;
  logic s_axi_rvalid;
  logic s_axi_rready;
  modport slave (
    input s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
    input s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );
  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
    output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid, s_axi_rready,
    input s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );
endinterface

// File: rtl/axi_ram_addr_gen.sv
// axi_ram_addr_gen: next beat address for FIXED/INCR/WRAP bursts
module axi_ram_addr_gen import axi_ram_pkg::*; #(
  parameter int ADDR_WIDTH = 12,
  parameter int STRB_WIDTH = 4
) (
  input logic [ADDR_WIDTH-1:0] addr,
  input logic [7:0] len,
  input logic [2:0] size,
  input logic [1:0] burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_WIDTH));
  logic [2:0] sz;
  logic [ADDR_WIDTH-1:0] incr, mask;
  logic wrap_ok;
  // Oversized beats clamp to the bus width; WRAP with an illegal length degrades to INCR
  always_comb begin
    sz = size > SIZE_MAX ? SIZE_MAX : size;
    incr = addr + (ADDR_WIDTH'(1) << sz);
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
    wrap_ok = burst == BURST_WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    next_addr = burst == BURST_FIXED ? addr : wrap_ok ? (addr & ~mask) | (incr & mask) : incr;
  end
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 burst RAM with independent write and read channel FSMs
module axi_ram_slave import axi_ram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input logic clk,
  input logic rst,
  axi_ram_slave_if.slave s
);
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH / STRB_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [ADDR_WIDTH-1:0] waddr, waddr_nx, raddr, raddr_nx;
  logic [7:0] wlen, wcnt, rlen, rcnt;
  logic [2:0] wsize, rsize;
  logic [1:0] wburst, rburst;
  logic werr, aw_hs, w_hs, b_hs, ar_hs, r_hs, r_end;
  logic [DATA_WIDTH-1:0] rdata_q;
  axi_ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_wgen (
    .addr(waddr), .len(wlen), .size(wsize), .burst(wburst), .next_addr(waddr_nx)
  );
  axi_ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_rgen (
    .addr(raddr), .len(rlen), .size(rsize), .burst(rburst), .next_addr(raddr_nx)
  );
  // Channel outputs from state, forced idle while reset is asserted, plus next-state decode
  always_comb begin
    s.s_axi_awready = !rst && w_state == W_IDLE;
    s.s_axi_wready = !rst && w_state == W_BURST;
    s.s_axi_bvalid = !rst && w_state == W_RESP;
    s.s_axi_bresp = s.s_axi_bvalid && werr ? RESP_SLVERR : RESP_OKAY;
    s.s_axi_arready = !rst && r_state == R_IDLE;
    s.s_axi_rvalid = !rst && r_state == R_BURST;
    s.s_axi_rlast = s.s_axi_rvalid && rcnt == rlen;
    s.s_axi_rdata = rst ? '0 : rdata_q;
    s.s_axi_rresp = RESP_OKAY;
    aw_hs = s.s_axi_awvalid && s.s_axi_awready;
    w_hs = s.s_axi_wvalid && s.s_axi_wready;
    b_hs = s.s_axi_bvalid && s.s_axi_bready;
    ar_hs = s.s_axi_arvalid && s.s_axi_arready;
    r_hs = s.s_axi_rvalid && s.s_axi_rready;
    r_end = rcnt == rlen;
    w_next = aw_hs ? W_BURST : (w_hs && wcnt == wlen) ? W_RESP : b_hs ? W_IDLE : w_state;
    r_next = ar_hs ? R_BURST : (r_hs && r_end) ? R_IDLE : r_state;
  end
  // State registers for both channels
  always_ff @(posedge clk) begin
    w_state <= rst ? W_IDLE : w_next;
    r_state <= rst ? R_IDLE : r_next;
  end
  // Write burst tracking; the beat counter alone ends the burst, wlast only grades it
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      waddr <= s.s_axi_awaddr;
      wlen <= s.s_axi_awlen;
      wsize <= s.s_axi_awsize;
      wburst <= s.s_axi_awburst;
      wcnt <= '0;
      werr <= 1'b0;
    end else if (w_hs) begin
      waddr <= waddr_nx;
      wcnt <= wcnt + 8'd1;
      werr <= werr | (s.s_axi_wlast != (wcnt == wlen));
    end
  end
  // Byte-lane masked memory write for each accepted beat
  always_ff @(posedge clk) begin
    if (w_hs)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (s.s_axi_wstrb[i]) mem[waddr[ADDR_WIDTH-1:LSB]][i*8 +: 8] <= s.s_axi_wdata[i*8 +: 8];
  end
  // Read burst: prefetch the next beat on each handshake so rdata stays put while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ar_hs) begin
      raddr <= s.s_axi_araddr;
      rlen <= s.s_axi_arlen;
      rsize <= s.s_axi_arsize;
      rburst <= s.s_axi_arburst;
      rcnt <= '0;
      rdata_q <= mem[s.s_axi_araddr[ADDR_WIDTH-1:LSB]];
    end else if (r_hs && !r_end) begin
      raddr <= raddr_nx;
      rcnt <= rcnt + 8'd1;
      rdata_q <= mem[raddr_nx[ADDR_WIDTH-1:LSB]];
    end
  end
endmodule
